// File: rtl/aca_recovery_unit.sv
// Purpose : exact-sum recovery stage behind an 8-bit ACA speculative adder (carry window WIN).
// Latency : 1 cycle when no carry window is fully propagating, 2 cycles when a fix-up add is needed.
// Backpr. : one result buffered; in_ready drops in FIX and while a held result is not taken.
//
// Ports:
//   clk, rst                 single rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      operand beat handshake (A, B, Cin, spec_sum, spec_cout)
//   out_valid / out_ready    result handshake (Sum, Cout, corrected, mispredict)
//   corrected                result came from the fix-up adder
//   mispredict               fix-up result differed from the speculative one (0 when corrected=0)
// Optional (`ACA_RECOVERY_STATS_EN): stat_ops, stat_fix, stat_miss, 16-bit saturating counters
//   of completed transfers, corrected transfers and mispredicted transfers.

module aca_recovery_unit #(
  parameter int WIDTH = 8,
  parameter int WIN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [WIDTH-1:0] spec_sum,
  input  logic             spec_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             corrected,
  output logic             mispredict
`ifdef ACA_RECOVERY_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_fix,
  output logic [15:0]      stat_miss
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FIX  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operand beat as captured on accept; only consumed by the fix-up path.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] ssum;
    logic             scout;
  } beat_t;

  logic [1:0]     state;
  beat_t          beat_r;
  logic [WIDTH-1:0] p;
  logic           err;
  logic           accept;
  logic           xfer;
  logic [WIDTH:0] exact;

  // A speculative result can only be wrong if some carry had to travel further
  // than WIN bits, i.e. some WIN-long run of propagate bits starting at bit 1
  // or above is all ones. Flagging those runs is conservative.
  always_comb begin
    p   = A ^ B;
    err = 1'b0;
    for (int j = WIN; j < WIDTH; j++) begin
      err = err | (&p[j -: WIN]);
    end
  end

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  assign exact = {1'b0, beat_r.a} + {1'b0, beat_r.b} + {{WIDTH{1'b0}}, beat_r.cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      beat_r     <= '0;
      Sum        <= '0;
      Cout       <= 1'b0;
      corrected  <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            beat_r <= '{a: A, b: B, cin: Cin, ssum: spec_sum, scout: spec_cout};
            if (err) begin
              state <= ST_FIX;
            end else begin
              // Unflagged: the speculative result is exact, present it directly.
              state      <= ST_DONE;
              Sum        <= spec_sum;
              Cout       <= spec_cout;
              corrected  <= 1'b0;
              mispredict <= 1'b0;
            end
          end else if (state == ST_DONE && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_FIX: begin
          state      <= ST_DONE;
          {Cout, Sum} <= exact;
          corrected  <= 1'b1;
          mispredict <= (exact != {beat_r.scout, beat_r.ssum});
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ACA_RECOVERY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_fix  <= '0;
      stat_miss <= '0;
    end else if (xfer) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (corrected && stat_fix != 16'hFFFF) stat_fix <= stat_fix + 16'd1;
      if (mispredict && stat_miss != 16'hFFFF) stat_miss <= stat_miss + 16'd1;
    end
  end
`else
  // Transfer strobe is only consumed by the statistics counters.
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: doc/aca_recovery_unit.md
# aca_recovery_unit

Variable-latency wrapper that sits directly downstream of the 8-bit accuracy-configurable speculative adder (ACA, 4-bit carry window). It registers the operands together with the adder's speculative Sum/Cout and runs error detection on the carry windows. On a flagged operand pair it spends one extra cycle producing the exact sum. The result is an exact adder with a valid/ready stream interface: 1-cycle latency on the common path, 2 cycles on the corrected path.

## Interface
- `WIDTH`, 8: operand width; must match the upstream adder.
- `WIN`, 4: speculative carry window length; must match the upstream adder; 1 ≤ WIN < WIDTH.
- `clk` input 1: the single clock; everything is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: unit can accept a beat this cycle.
- `A`, `B` input WIDTH: operands.
- `Cin` input 1: carry in.
- `spec_sum` input WIDTH: speculative Sum from the adder; combinational from the same A/B/Cin.
- `spec_cout` input 1: speculative Cout from the adder.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `Sum` output WIDTH: exact A+B+Cin, low WIDTH bits.
- `Cout` output 1: exact carry out.
- `corrected` output 1: the result took the correction path.
- `mispredict` output 1: the speculative result differed from the exact result. Always 0 when `corrected`=0.

## Operation
- Propagate vector: P = A ^ B.
- Error flag: ERR = OR over i = WIN+1 .. WIDTH of (&P[i-1 : i-WIN]).
  - For WIDTH=8, WIN=4 this covers windows P[4:1] through P[7:4].
  - Detection is conservative: ERR may be 1 when the speculation is actually correct. ERR=0 guarantees the speculation is exact.
- Accept: the beat is accepted when `in_valid && in_ready`. On accept, register A, B, Cin, spec_sum, spec_cout and ERR.
- States:
  - IDLE: no result held. `in_ready`=1.
  - FIX: compute exact {Cout,Sum} = A_r + B_r + Cin_r (WIDTH+1-bit add). Compare it with the registered speculative value to set `mispredict`. `in_ready`=0.
  - DONE: `out_valid`=1; outputs are held stable until `out_ready`.
- Transitions:
  - IDLE, accept with ERR=0 → DONE. Sum/Cout = spec_sum/spec_cout; corrected=0; mispredict=0.
  - IDLE, accept with ERR=1 → FIX.
  - FIX → DONE unconditionally. corrected=1.
  - DONE with out_ready=1 → IDLE, or directly to DONE/FIX when a new beat is accepted in the same cycle.
  - DONE with out_ready=0 → stays in DONE.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). There is no combinational path from `in_valid` to `in_ready`.
- Reset values: state=IDLE, out_valid=0, Sum=0, Cout=0, corrected=0, mispredict=0, in_ready=1 (in the cycle after rst deasserts).
- Reset while in FIX or DONE discards the beat. No output handshake occurs for it.

## Timing
- Fast path: accept at edge N → out_valid=1 after edge N; transfer at the first edge with out_ready=1.
- Corrected path: accept at edge N → FIX after edge N → out_valid=1 after edge N+1.
- Throughput is one beat per cycle on the fast path when out_ready is held high. A flagged beat costs one bubble.
- Output stability: Sum, Cout, corrected and mispredict must not change while out_valid=1 && out_ready=0.
- Simultaneous rst and accept: reset wins and the beat is dropped.

## Configuration
- `ACA_RECOVERY_STATS_EN` defined adds three outputs: `stat_ops`, `stat_fix`, `stat_miss`, each 16 bits and saturating at 0xFFFF.
  - `stat_ops` counts completed output transfers.
  - `stat_fix` counts completed transfers with corrected=1.
  - `stat_miss` counts completed transfers with mispredict=1.
  - All three reset to 0 on rst.
- Undefined: these ports and counters are absent. Core behaviour is identical either way.

## Test plan
- Fast path: A=0x12, B=0x34, Cin=0, spec_sum=0x46, spec_cout=0, out_ready=1 → out_valid one cycle after accept; Sum=0x46, Cout=0, corrected=0.
- Real mispredict: A=0x1F, B=0x01, Cin=0, spec_sum=0x00, spec_cout=0 → ERR=1; result two cycles after accept; Sum=0x20, Cout=0, corrected=1, mispredict=1.
- Carry-out fix: A=0xFF, B=0x01, Cin=0, spec_sum=0x00, spec_cout=0 → Sum=0x00, Cout=1, corrected=1, mispredict=1.
- False alarm plus backpressure: A=0x1E, B=0x00, Cin=0, spec_sum=0x1E → corrected=1, mispredict=0, Sum=0x1E. Hold out_ready=0 for 3 cycles → outputs stable and in_ready=0 throughout; transfer on release.
- Streaming: 8 non-flagged beats back-to-back with out_ready=1 → one result per cycle, in order. Insert one flagged beat → exactly one bubble.
- Reset mid-FIX: assert rst in the FIX cycle → next cycle out_valid=0, in_ready=1, no transfer of that beat. With the stats macro defined, counters read 0.
